// File: rtl/vx_csr_bank.sv
// vx_csr_bank: per-warp floating-point and scratch CSRs plus shared
// mcycle/minstret counters, behind a one-entry request/response register.
// Reads return the pre-write value one cycle after accept.
// Optional feature: define VX_CSR_CTR_SNAPSHOT_EN so that a high-half
// counter read returns the high bits captured by the last low-half read.
`timescale 1ns/1ps

`ifndef CSR_LWID
`define CSR_LWID 12'hCC3
`endif
`ifndef CSR_GWID
`define CSR_GWID 12'hCC4
`endif
`ifndef CSR_NT
`define CSR_NT 12'hFC0
`endif
`ifndef CSR_NW
`define CSR_NW 12'hFC1
`endif
`ifndef CSR_NC
`define CSR_NC 12'hFC2
`endif

module vx_csr_bank #(
  parameter int  CORE_ID     = 0,
  parameter int  NUM_WARPS   = 4,
  parameter int  CTR_WIDTH   = 48,
  parameter int  CMT_BITS    = 3,
  parameter int  NUM_THREADS = 4,
  parameter int  NUM_CORES   = 1,
  localparam int NW          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [11:0]         req_addr,
  input  logic [NW-1:0]       req_wid,
  input  logic [31:0]         req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [NW-1:0]       rsp_wid,
  output logic                rsp_err,
  input  logic                fpu_valid,
  input  logic [NW-1:0]       fpu_wid,
  input  logic [4:0]          fpu_fflags,
  input  logic [NW-1:0]       frm_wid,
  output logic [2:0]          frm,
  input  logic                busy,
  input  logic                commit_valid,
  input  logic [CMT_BITS-1:0] commit_size
);

  localparam logic [11:0] ADDR_FFLAGS    = 12'h001;
  localparam logic [11:0] ADDR_FRM       = 12'h002;
  localparam logic [11:0] ADDR_FCSR      = 12'h003;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_nxt;
  logic                 accept, wr_en;
  logic [31:0]          rd_data;
  logic                 rd_err;

  logic [4:0]           fflags     [NUM_WARPS];
  logic [4:0]           fflags_nxt [NUM_WARPS];
  logic [2:0]           frm_r      [NUM_WARPS];
  logic [31:0]          mscratch   [NUM_WARPS];
  logic [CTR_WIDTH-1:0] mcycle, minstret;
  logic [CTR_WIDTH-33:0] mcycle_hi, minstret_hi;

  // Response register next state; a full slot frees up when it is drained.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    state_nxt = state;
    req_ready = (state == EMPTY) || rsp_ready;
    if (req_valid && req_ready) begin
      state_nxt = FULL;
    end else if (rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_write;
  assign rsp_valid = (state == FULL);
  assign frm       = frm_r[frm_wid];

  // Response state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef VX_CSR_CTR_SNAPSHOT_EN
  logic [CTR_WIDTH-33:0] mcycle_shadow, minstret_shadow;

  // Capture counter high bits when the matching low half is read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_shadow   <= '0;
      minstret_shadow <= '0;
    end else if (accept) begin
      if (req_addr == ADDR_MCYCLE)   mcycle_shadow   <= mcycle[CTR_WIDTH-1:32];
      if (req_addr == ADDR_MINSTRET) minstret_shadow <= minstret[CTR_WIDTH-1:32];
    end
  end

  assign mcycle_hi   = mcycle_shadow;
  assign minstret_hi = minstret_shadow;
`else
  assign mcycle_hi   = mcycle[CTR_WIDTH-1:32];
  assign minstret_hi = minstret[CTR_WIDTH-1:32];
`endif

  // Read mux: value before any write in this cycle; unknown address flags err.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (req_addr)
      ADDR_FFLAGS:    rd_data = {27'd0, fflags[req_wid]};
      ADDR_FRM:       rd_data = {29'd0, frm_r[req_wid]};
      ADDR_FCSR:      rd_data = {24'd0, frm_r[req_wid], fflags[req_wid]};
      ADDR_MSCRATCH:  rd_data = mscratch[req_wid];
      ADDR_MCYCLE:    rd_data = mcycle[31:0];
      ADDR_MCYCLEH:   rd_data = 32'(mcycle_hi);
      ADDR_MINSTRET:  rd_data = minstret[31:0];
      ADDR_MINSTRETH: rd_data = 32'(minstret_hi);
      `CSR_LWID:      rd_data = 32'(req_wid);
      `CSR_GWID:      rd_data = 32'(CORE_ID * NUM_WARPS) + 32'(req_wid);
      `CSR_NT:        rd_data = 32'(NUM_THREADS);
      `CSR_NW:        rd_data = 32'(NUM_WARPS);
      `CSR_NC:        rd_data = 32'(NUM_CORES);
      default:        rd_err  = 1'b1;
    endcase
  end

  // Next fflags: a software write lands first, FPU exceptions accumulate on top.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fflags_nxt[w] = fflags[w];
      if (wr_en && (req_wid == NW'(w)) &&
          (req_addr == ADDR_FFLAGS || req_addr == ADDR_FCSR)) begin
        fflags_nxt[w] = req_data[4:0];
      end
      if (fpu_valid && (fpu_wid == NW'(w))) begin
        fflags_nxt[w] = fflags_nxt[w] | fpu_fflags;
      end
    end
  end

  // Per-warp CSR storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these arrays are small and software-visible, so each entry is
      // cleared on reset instead of being treated as uninitialised RAM.
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags[w]   <= '0;
        frm_r[w]    <= '0;
        mscratch[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags[w] <= fflags_nxt[w];
        if (wr_en && (req_wid == NW'(w))) begin
          if (req_addr == ADDR_FRM)      frm_r[w]    <= req_data[2:0];
          if (req_addr == ADDR_FCSR)     frm_r[w]    <= req_data[7:5];
          if (req_addr == ADDR_MSCRATCH) mscratch[w] <= req_data;
        end
      end
    end
  end

  // Free-running performance counters; software writes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle + CTR_WIDTH'(busy);
      minstret <= minstret + (commit_valid ? CTR_WIDTH'(commit_size) : '0);
    end
  end

  // Response payload, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_wid  <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_data <= rd_data;
      rsp_wid  <= req_wid;
      rsp_err  <= rd_err;
    end
  end

endmodule

// File: tb/tb_vx_csr_bank.sv
// tb_vx_csr_bank: scoreboard bench for vx_csr_bank. A reference model of the
// CSR contents predicts each response when a request is accepted; a separate
// monitor compares every presented response against the queue head.
`timescale 1ns/1ps

module tb_vx_csr_bank;

  localparam int CORE_ID     = 2;
  localparam int NUM_WARPS   = 4;
  localparam int CTR_WIDTH   = 48;
  localparam int CMT_BITS    = 3;
  localparam int NUM_THREADS = 8;
  localparam int NUM_CORES   = 3;
  localparam int NW          = 2;
  localparam longint unsigned CTR_MASK = (64'd1 << CTR_WIDTH) - 64'd1;
  localparam longint unsigned LOW32    = 64'h1_0000_0000;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [11:0]         req_addr = '0;
  logic [NW-1:0]       req_wid = '0;
  logic [31:0]         req_data = '0;
  logic                rsp_valid, rsp_ready = 1'b1;
  logic [31:0]         rsp_data;
  logic [NW-1:0]       rsp_wid;
  logic                rsp_err;
  logic                fpu_valid = 1'b0;
  logic [NW-1:0]       fpu_wid = '0;
  logic [4:0]          fpu_fflags = '0;
  logic [NW-1:0]       frm_wid = '0;
  logic [2:0]          frm;
  logic                busy = 1'b0, commit_valid = 1'b0;
  logic [CMT_BITS-1:0] commit_size = '0;

  vx_csr_bank #(
    .CORE_ID(CORE_ID), .NUM_WARPS(NUM_WARPS), .CTR_WIDTH(CTR_WIDTH),
    .CMT_BITS(CMT_BITS), .NUM_THREADS(NUM_THREADS), .NUM_CORES(NUM_CORES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wid(req_wid), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wid(rsp_wid), .rsp_err(rsp_err),
    .fpu_valid(fpu_valid), .fpu_wid(fpu_wid), .fpu_fflags(fpu_fflags),
    .frm_wid(frm_wid), .frm(frm),
    .busy(busy), .commit_valid(commit_valid), .commit_size(commit_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned data;
    int unsigned     wid;
    bit              err;
  } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural CSR contents as plain numbers.
  int unsigned     m_fflags   [NUM_WARPS];
  int unsigned     m_frm      [NUM_WARPS];
  int unsigned     m_mscratch [NUM_WARPS];
  longint unsigned m_mcycle, m_minstret, m_mcycle_snap, m_minstret_snap;
  bit              m_full;
  rsp_t            exp_q[$];

  logic [11:0] addr_pool [16] = '{12'h001, 12'h002, 12'h003, 12'h340,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                  12'hCC3, 12'hCC4, 12'hFC0, 12'hFC1,
                                  12'hFC2, 12'h7FF, 12'h000, 12'hB01};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) begin
      m_fflags[w] = 0; m_frm[w] = 0; m_mscratch[w] = 0;
    end
    m_mcycle = 0; m_minstret = 0; m_mcycle_snap = 0; m_minstret_snap = 0;
    m_full = 1'b0;
    exp_q.delete();
  endtask

  function automatic rsp_t model_read(input logic [11:0] a, input int unsigned w);
    rsp_t r;
    r.data = 0; r.wid = w; r.err = 1'b0;
    case (a)
      12'h001: r.data = m_fflags[w];
      12'h002: r.data = m_frm[w];
      12'h003: r.data = m_frm[w] * 32 + m_fflags[w];
      12'h340: r.data = m_mscratch[w];
      12'hB00: r.data = m_mcycle % LOW32;
      12'hB02: r.data = m_minstret % LOW32;
`ifdef VX_CSR_CTR_SNAPSHOT_EN
      12'hB80: r.data = m_mcycle_snap;
      12'hB82: r.data = m_minstret_snap;
`else
      12'hB80: r.data = m_mcycle / LOW32;
      12'hB82: r.data = m_minstret / LOW32;
`endif
      12'hCC3: r.data = w;
      12'hCC4: r.data = CORE_ID * NUM_WARPS + w;
      12'hFC0: r.data = NUM_THREADS;
      12'hFC1: r.data = NUM_WARPS;
      12'hFC2: r.data = NUM_CORES;
      default: r.err  = 1'b1;
    endcase
    return r;
  endfunction

  // One clock of the model, evaluated with this cycle's inputs applied.
  task automatic model_cycle();
    bit   ready, acc;
    rsp_t e;
    ready = !m_full || rsp_ready;
    check("req_ready", 64'(req_ready), 64'(ready));
    check("rsp_valid", 64'(rsp_valid), 64'(m_full));
    check("frm_out", 64'(frm), 64'(m_frm[frm_wid]));
    acc = req_valid && ready;
    if (acc) begin
      e = model_read(req_addr, req_wid);
      exp_q.push_back(e);
`ifdef VX_CSR_CTR_SNAPSHOT_EN
      if (req_addr == 12'hB00) m_mcycle_snap   = m_mcycle / LOW32;
      if (req_addr == 12'hB02) m_minstret_snap = m_minstret / LOW32;
`endif
      if (req_write) begin
        case (req_addr)
          12'h001: m_fflags[req_wid] = req_data % 32;
          12'h002: m_frm[req_wid]    = req_data % 8;
          12'h003: begin
            m_fflags[req_wid] = req_data % 32;
            m_frm[req_wid]    = (req_data / 32) % 8;
          end
          12'h340: m_mscratch[req_wid] = req_data;
          default: ;
        endcase
      end
    end
    if (fpu_valid) m_fflags[fpu_wid] = m_fflags[fpu_wid] | fpu_fflags;
    if (busy) m_mcycle = (m_mcycle + 1) & CTR_MASK;
    if (commit_valid) m_minstret = (m_minstret + commit_size) & CTR_MASK;
    m_full = acc || (m_full && !rsp_ready);
  endtask

  task automatic step();
    #1;
    model_cycle();
    @(negedge clk);
  endtask

  task automatic step_frm_expect(input logic [2:0] e);
    #1;
    check("frm_direct", 64'(frm), 64'(e));
    model_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b1;
    busy = 1'b0; fpu_valid = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic req(input bit wr, input logic [11:0] a, input logic [NW-1:0] w, input logic [31:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wid = w; req_data = d;
    step();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Monitor: compare each presented response against the scoreboard head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q[0];
          check("rsp_data", 64'(rsp_data), e.data);
          check("rsp_wid", 64'(rsp_wid), 64'(e.wid));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready) e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_rsp_wid", 64'(rsp_wid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Ten busy cycles, then read mcycle low.
    busy = 1'b1;
    repeat (10) step();
    busy = 1'b0;
    req(1'b0, 12'hB00, 2'd0, 32'd0);

    // fcsr write splits into frm/fflags; other warps untouched.
    req(1'b1, 12'h003, 2'd1, 32'hE5);
    req(1'b0, 12'h002, 2'd1, 32'd0);
    req(1'b0, 12'h001, 2'd0, 32'd0);
    frm_wid = 2'd1;
    step_frm_expect(3'd7);

    // Same-cycle software write and FPU flags, then a read racing the FPU.
    fpu_valid = 1'b1; fpu_wid = 2'd2; fpu_fflags = 5'h04;
    req(1'b1, 12'h001, 2'd2, 32'h01);
    fpu_valid = 1'b0;
    req(1'b0, 12'h001, 2'd2, 32'd0);
    fpu_valid = 1'b1; fpu_wid = 2'd3; fpu_fflags = 5'h0A;
    req(1'b0, 12'h001, 2'd3, 32'd0);
    fpu_valid = 1'b0;
    req(1'b0, 12'h001, 2'd3, 32'd0);

    // Back-pressure: stall three cycles, then stream one per cycle.
    req(1'b1, 12'h340, 2'd0, 32'hDEAD_BEEF);
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    req_addr = 12'h340; req_wid = 2'd0;
    repeat (3) step();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = addr_pool[i]; req_wid = NW'(i);
      step();
    end
    req_valid = 1'b0;
    step();

    // Unknown address, ignored writes, identity constants.
    req(1'b0, 12'h7FF, 2'd1, 32'd0);
    req(1'b1, 12'hB00, 2'd0, 32'h1234);
    req(1'b1, 12'hCC4, 2'd3, 32'h55);
    req(1'b0, 12'hCC4, 2'd3, 32'd0);
    req(1'b0, 12'hFC0, 2'd0, 32'd0);
    req(1'b0, 12'hFC2, 2'd0, 32'd0);
    step();

    // mcycle low-half rollover across a low/high read pair.
    idle_inputs();
    step();
    force dut.mcycle = 48'h0000_FFFF_FFFF;
    #1;
    release dut.mcycle;
    m_mcycle = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    busy = 1'b1;
    req(1'b0, 12'hB00, 2'd0, 32'd0);
    step();
    req(1'b0, 12'hB80, 2'd0, 32'd0);
    busy = 1'b0;
    step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      req_write    = $urandom_range(0, 1);
      req_addr     = addr_pool[$urandom_range(0, 15)];
      req_wid      = NW'($urandom);
      req_data     = $urandom;
      rsp_ready    = ($urandom_range(0, 3) != 0);
      busy         = $urandom_range(0, 1);
      fpu_valid    = $urandom_range(0, 1);
      fpu_wid      = NW'($urandom);
      fpu_fflags   = 5'($urandom);
      frm_wid      = NW'($urandom);
      commit_valid = $urandom_range(0, 1);
      commit_size  = CMT_BITS'($urandom);
      step();
    end
    idle_inputs();
    step();
    step();

    // Asynchronous reset while a response is pending.
    rsp_ready = 1'b0;
    req(1'b0, 12'h001, 2'd1, 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("async_rst_rsp_err", 64'(rsp_err), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    req(1'b0, 12'h001, 2'd1, 32'd0);
    req(1'b0, 12'h002, 2'd1, 32'd0);
    req(1'b0, 12'hB00, 2'd0, 32'd0);

    // Drain with a bounded cycle budget.
    idle_inputs();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_csr_bank.md
VX_CSR_BANK -- requirements
Module: VX_csr_bank

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index used in global warp ID.
REQ-002 SHALL have parameter NUM_WARPS, default 4, number of per-warp CSR copies (1..32); NW = max(1, clog2(NUM_WARPS)).
REQ-003 SHALL have parameter CTR_WIDTH, default 48, width of mcycle/minstret counters (33..64).
REQ-004 SHALL have parameter CMT_BITS, default 3, width of commit_size.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 req_valid/req_ready  in/out  1/1  request handshake.
REQ-008 req_write  in  1  1 = read-old-value-then-write, 0 = read only.
REQ-009 req_addr  in  12  CSR address; req_wid  in  NW  warp; req_data  in  32  write data.
REQ-010 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 rsp_data  out  32; rsp_wid  out  NW; rsp_err  out  1  unknown address.
REQ-012 fpu_valid  in  1; fpu_wid  in  NW; fpu_fflags  in  5  exception flags to accumulate.
REQ-013 frm_wid  in  NW; frm  out  3  combinational rounding mode of frm_wid.
REQ-014 busy  in  1  core active; commit_valid  in  1; commit_size  in  CMT_BITS  instructions retired.

Function
REQ-015 Response register SHALL have two states, EMPTY and FULL; req_ready = EMPTY or rsp_ready.
REQ-016 Accept = req_valid and req_ready; on accept, state SHALL be FULL next cycle with rsp_data = pre-write value (latency 1).
REQ-017 FULL with rsp_ready and no accept SHALL go EMPTY; FULL with rsp_ready and accept SHALL stay FULL with new data (back-to-back, one per cycle).
REQ-018 While FULL and rsp_ready=0, rsp_data/rsp_wid/rsp_err SHALL hold stable.
REQ-019 Per-warp state: fflags[4:0], frm[2:0], mscratch[31:0]; shared: mcycle, minstret (CTR_WIDTH each).
REQ-020 Addresses: 0x001 fflags, 0x002 frm, 0x003 fcsr = {frm,fflags}, 0x340 mscratch, 0xB00/0xB80 mcycle low/high, 0xB02/0xB82 minstret low/high, `CSR_NT/`CSR_NW/`CSR_NC constants, `CSR_LWID = wid, `CSR_GWID = CORE_ID*NUM_WARPS + wid.
REQ-021 Writes SHALL take effect on accept cycle edge; writes to read-only or counter addresses SHALL be ignored with rsp_err=0.
REQ-022 Unknown address SHALL give rsp_data=0, rsp_err=1, no state change.
REQ-023 High-half reads SHALL return counter[CTR_WIDTH-1:32] zero-extended to 32 bits.
REQ-024 mcycle SHALL increment by 1 each cycle busy=1; minstret SHALL add commit_size when commit_valid=1; both wrap modulo 2^CTR_WIDTH.
REQ-025 fpu_valid SHALL OR fpu_fflags into fflags[fpu_wid].
REQ-026 Same-cycle accepted fflags/fcsr write and fpu_valid to same warp: fflags = write_data[4:0] | fpu_fflags.
REQ-027 Read of fflags in same cycle as fpu_valid SHALL return value before the OR.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately clear all CSRs, counters, shadows, state EMPTY, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_wid=0; pending response discarded.
REQ-029 req_ready SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-030 Macro VX_CSR_CTR_SNAPSHOT_EN defined: reading 0xB00 (0xB02) SHALL latch the high bits of the same counter value into a shadow register; 0xB80 (0xB82) SHALL return the shadow.
REQ-031 Macro undefined: no shadow registers; high-half reads SHALL return live counter high bits.

Verification
REQ-032 Reset, busy=1 ten cycles, read 0xB00 -> rsp_data=10, rsp_err=0, one cycle after accept.
REQ-033 Write 0x003 data 0xE5 wid 1, then read 0x002 wid 1 -> 0x7; read 0x001 wid 0 -> 0x0; frm_wid=1 -> frm=7.
REQ-034 rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_data stable; rsp_ready=1 -> one response per cycle thereafter.
REQ-035 Write 0x001 data 0x01 with same-cycle fpu_valid fflags 0x04 same wid -> later read 0x001 = 0x05.
REQ-036 Preload mcycle = 0x0000_0000_FFFF_FFFF, busy=1, read 0xB00 then 0xB80 two cycles later -> with VX_CSR_CTR_SNAPSHOT_EN 0xFFFFFFFF then 0x0; without 0xFFFFFFFF then 0x1.
REQ-037 Read 0x7FF -> rsp_err=1, rsp_data=0; reset_n pulsed while FULL -> rsp_valid=0 immediately.
